tlc_phase_fsm: RTL and testbench
================================

Name: tlc_phase_fsm

Overview:
Traffic-light phase sequencer that sits directly upstream of the per-phase countdown timer. It drives the timer's reload, load value and enable, and consumes its count and done outputs. It steps the intersection through the NS/EW green-yellow-all-red cycle, with an optional pedestrian-walk phase and a maintenance flash mode. It also drives the lamp outputs for both approaches and the walk signal.

Parameters:
GREEN_TIME, 4'd8, green duration in timer seconds (legal range 1..15)
YELLOW_TIME, 4'd3, yellow duration (1..15)
RED_TIME, 4'd2, all-red clearance duration (1..15)
PED_TIME, 4'd6, pedestrian walk duration (1..15)
FLASH_TIME, 4'd1, flash half-period (1..15)

Ports:
clk  in  1  system clock; single clock domain
reset_n  in  1  asynchronous, active-low reset
ped_req  in  1  pedestrian button, level or pulse; latched internally
flash_mode  in  1  maintenance flash request
timer_count  in  4  timer remaining seconds (debug and visibility only)
timer_done  in  1  timer expired flag
timer_reload  out  1  one-cycle reload strobe to the timer
timer_load_value  out  4  duration for the current phase
timer_enable  out  1  timer run enable
ns_light  out  3  north-south lamps {red, yellow, green}
ew_light  out  3  east-west lamps {red, yellow, green}
ped_walk  out  1  walk lamp
phase  out  3  current state encoding, for debug

Behaviour:
- All outputs are registered.
- Reset (reset_n low, asynchronous):
  - state = ALL_RED_2
  - ns_light = ew_light = 3'b100
  - ped_walk = 0
  - ped latch = 0
  - timer_enable = 1
  - timer_reload = 1
  - timer_load_value = RED_TIME
- The first cycle after reset release therefore loads the clearance time into the timer.
- States and durations:
  - NS_GREEN (GREEN_TIME)
  - NS_YELLOW (YELLOW_TIME)
  - ALL_RED_1 (RED_TIME)
  - EW_GREEN (GREEN_TIME)
  - EW_YELLOW (YELLOW_TIME)
  - ALL_RED_2 (RED_TIME)
  - PED_WALK (PED_TIME)
  - FLASH_ON (FLASH_TIME)
  - FLASH_OFF (FLASH_TIME)
- Advance condition: `expire = timer_done & ~timer_reload`.
  - The timer's done is stale during the reload cycle, so done must be masked there.
- Normal sequence on expire: NS_GREEN -> NS_YELLOW -> ALL_RED_1 -> EW_GREEN -> EW_YELLOW -> ALL_RED_2 -> (ped latch ? PED_WALK : NS_GREEN).
- PED_WALK -> NS_GREEN on expire.
- On every state change at clock edge T:
  - state <= next
  - timer_load_value <= duration(next)
  - timer_reload <= 1 for exactly one cycle, so the timer loads at edge T+1
  - timer_load_value is held constant for the whole phase
- Phase length is duration × timer second + 2 clk cycles.
- timer_enable is 1 in every state after reset.
- Lamps:
  - NS_GREEN: ns = 001, ew = 100
  - NS_YELLOW: ns = 010, ew = 100
  - EW_GREEN: ns = 100, ew = 001
  - EW_YELLOW: ns = 100, ew = 010
  - ALL_RED_x and PED_WALK: both 100
  - FLASH_ON: both 010
  - FLASH_OFF: both 000
  - ped_walk = 1 only in PED_WALK
- Lamps update in the same edge as the state.
- Pedestrian latch:
  - Set on any cycle with ped_req = 1.
  - Cleared on the edge that enters PED_WALK.
  - If ped_req is asserted on that same edge, the clear wins; the request is re-latched the next cycle only if still asserted.
- Flash mode:
  - flash_mode is sampled only at expire.
  - If flash_mode = 1 at expire in any non-flash state, next = FLASH_ON. This overrides the normal successor, including when leaving green.
  - FLASH_ON <-> FLASH_OFF alternate on each expire while flash_mode = 1.
  - At expire with flash_mode = 0 in either flash state, next = ALL_RED_2.
  - The ped latch keeps its value through flash.
- Simultaneous ped_req and flash_mode at ALL_RED_2 expire: flash has priority; the latch is retained.
- Illegal state encoding recovers to ALL_RED_2 with a reload.
- Reset mid-phase: immediate return to reset values; no partial lamp states are allowed.

Decomposition:
- Package tlc_pkg holds:
  - the state enum (3-bit encodings plus the two flash states; width 4 if needed)
  - light constants LAMP_RED = 3'b100, LAMP_YEL = 3'b010, LAMP_GRN = 3'b001, LAMP_OFF = 3'b000
- No sub-module. The next-state, duration and lamp decode are combinational functions inside the module.
- The timer is instantiated alongside this block at the top level, not inside it.

Test Plan:
- Reset release with timer TICKS_PER_SECOND = 4 and defaults:
  - timer_reload is high in the first cycle, load_value = 2.
  - After 2 timer seconds + 2 cycles, phase = NS_GREEN, ns_light = 001, timer_load_value = 8, timer_reload pulses once.
- Free-run one full cycle:
  - States visit NS_G, NS_Y, AR1, EW_G, EW_Y, AR2, NS_G in order.
  - Each phase lasts duration×4 + 2 cycles, i.e. 34, 14, 10, 34, 14, 10.
- One-cycle ped_req pulse during EW_GREEN:
  - AR2 -> PED_WALK with ped_walk = 1, both lamps 100, load_value = 6.
  - Then NS_GREEN; the next cycle skips PED_WALK.
- flash_mode = 1 asserted mid NS_GREEN:
  - Green runs to expiry, then FLASH_ON (both 010) and FLASH_OFF (000) alternate every 1 s.
  - Deassert -> ALL_RED_2, then NS_GREEN.
- Force timer_done = 1 during a reload cycle: no state advance occurs.
- Assert reset_n low mid EW_YELLOW:
  - Lamps go to 100/100 asynchronously, ped_walk = 0.
  - After release, the reset sequence repeats exactly.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared state codes, lamp patterns and state-classification helpers for the
// traffic-light phase sequencer.
package tlc_pkg;

    typedef logic [3:0] tlc_state_t;

    localparam tlc_state_t ST_NS_GREEN  = 4'd0;
    localparam tlc_state_t ST_NS_YELLOW = 4'd1;
    localparam tlc_state_t ST_ALL_RED_1 = 4'd2;
    localparam tlc_state_t ST_EW_GREEN  = 4'd3;
    localparam tlc_state_t ST_EW_YELLOW = 4'd4;
    localparam tlc_state_t ST_ALL_RED_2 = 4'd5;
    localparam tlc_state_t ST_PED_WALK  = 4'd6;
    localparam tlc_state_t ST_FLASH_ON  = 4'd8;
    localparam tlc_state_t ST_FLASH_OFF = 4'd9;

    // Both flash states report this otherwise unused 3-bit code on the debug
    // phase port; the lamps tell FLASH_ON and FLASH_OFF apart.
    localparam logic [2:0] PHASE_FLASH = 3'b111;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    function automatic logic st_is_flash(input tlc_state_t s);
        return (s == ST_FLASH_ON) || (s == ST_FLASH_OFF);
    endfunction

    function automatic logic st_is_legal(input tlc_state_t s);
        case (s)
            ST_NS_GREEN, ST_NS_YELLOW, ST_ALL_RED_1,
            ST_EW_GREEN, ST_EW_YELLOW, ST_ALL_RED_2,
            ST_PED_WALK, ST_FLASH_ON, ST_FLASH_OFF: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tlc_phase_fsm.sv
// Traffic-light phase sequencer: steps NS/EW green-yellow-all-red, optional
// pedestrian walk and maintenance flash, driving the external phase timer.
module tlc_phase_fsm
    import tlc_pkg::*;
#(
    parameter logic [3:0] GREEN_TIME  = 4'd8,
    parameter logic [3:0] YELLOW_TIME = 4'd3,
    parameter logic [3:0] RED_TIME    = 4'd2,
    parameter logic [3:0] PED_TIME    = 4'd6,
    parameter logic [3:0] FLASH_TIME  = 4'd1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ped_req,
    input  logic       flash_mode,
    input  logic [3:0] timer_count,
    input  logic       timer_done,
    output logic       timer_reload,
    output logic [3:0] timer_load_value,
    output logic       timer_enable,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic [2:0] phase
);

    tlc_state_t r_state;
    logic       r_reload;
    logic [3:0] r_load_value;
    logic       r_enable;
    logic [2:0] r_ns;
    logic [2:0] r_ew;
    logic       r_walk;
    logic [2:0] r_phase;
    logic       r_ped_latch;

    logic       w_expire;
    logic       w_illegal;
    logic       w_change;
    logic       w_enter_ped;
    tlc_state_t w_next;

    function automatic logic [3:0] f_duration(input tlc_state_t s);
        case (s)
            ST_NS_GREEN,  ST_EW_GREEN:  return GREEN_TIME;
            ST_NS_YELLOW, ST_EW_YELLOW: return YELLOW_TIME;
            ST_PED_WALK:                return PED_TIME;
            ST_FLASH_ON,  ST_FLASH_OFF: return FLASH_TIME;
            default:                    return RED_TIME;
        endcase
    endfunction

    // Flash request overrides every normal successor; leaving flash always
    // passes through the all-red clearance before traffic resumes.
    function automatic tlc_state_t f_next(input tlc_state_t s, input logic ped,
                                          input logic flash);
        if (st_is_flash(s))
            return flash ? ((s == ST_FLASH_ON) ? ST_FLASH_OFF : ST_FLASH_ON)
                         : ST_ALL_RED_2;
        if (flash)
            return ST_FLASH_ON;
        case (s)
            ST_NS_GREEN:  return ST_NS_YELLOW;
            ST_NS_YELLOW: return ST_ALL_RED_1;
            ST_ALL_RED_1: return ST_EW_GREEN;
            ST_EW_GREEN:  return ST_EW_YELLOW;
            ST_EW_YELLOW: return ST_ALL_RED_2;
            ST_ALL_RED_2: return ped ? ST_PED_WALK : ST_NS_GREEN;
            ST_PED_WALK:  return ST_NS_GREEN;
            default:      return ST_ALL_RED_2;
        endcase
    endfunction

    // Packed as {ns, ew}.
    function automatic logic [5:0] f_lamps(input tlc_state_t s);
        case (s)
            ST_NS_GREEN:  return {LAMP_GRN, LAMP_RED};
            ST_NS_YELLOW: return {LAMP_YEL, LAMP_RED};
            ST_EW_GREEN:  return {LAMP_RED, LAMP_GRN};
            ST_EW_YELLOW: return {LAMP_RED, LAMP_YEL};
            ST_FLASH_ON:  return {LAMP_YEL, LAMP_YEL};
            ST_FLASH_OFF: return {LAMP_OFF, LAMP_OFF};
            default:      return {LAMP_RED, LAMP_RED};
        endcase
    endfunction

    function automatic logic [2:0] f_phase(input tlc_state_t s);
        return st_is_flash(s) ? PHASE_FLASH : s[2:0];
    endfunction

    // timer_done still reflects the previous phase during the reload cycle.
    assign w_expire    = timer_done & ~r_reload;
    assign w_illegal   = ~st_is_legal(r_state);
    assign w_change    = w_expire | w_illegal;
    assign w_next      = w_illegal ? ST_ALL_RED_2
                                   : f_next(r_state, r_ped_latch, flash_mode);
    assign w_enter_ped = w_change & (w_next == ST_PED_WALK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_ALL_RED_2;
            r_reload     <= 1'b1;
            r_load_value <= RED_TIME;
            r_enable     <= 1'b1;
            r_ns         <= LAMP_RED;
            r_ew         <= LAMP_RED;
            r_walk       <= 1'b0;
            r_phase      <= f_phase(ST_ALL_RED_2);
            r_ped_latch  <= 1'b0;
        end else begin
            r_enable    <= 1'b1;
            r_reload    <= w_change;
            r_ped_latch <= w_enter_ped ? 1'b0 : (r_ped_latch | ped_req);
            if (w_change) begin
                r_state        <= w_next;
                r_load_value   <= f_duration(w_next);
                {r_ns, r_ew}   <= f_lamps(w_next);
                r_walk         <= (w_next == ST_PED_WALK);
                r_phase        <= f_phase(w_next);
            end
        end
    end

    assign timer_reload     = r_reload;
    assign timer_load_value = r_load_value;
    assign timer_enable     = r_enable;
    assign ns_light         = r_ns;
    assign ew_light         = r_ew;
    assign ped_walk         = r_walk;
    assign phase            = r_phase;

    // A settled done from the timer must coincide with a zero count.
    a_done_means_zero: assert property (
        @(posedge clk) disable iff (!reset_n)
        (timer_done && !r_reload) |-> (timer_count == 4'd0)
    );

endmodule

// File: tb/tb_tlc_phase_fsm.sv
// Closed-loop bench: behavioural countdown timer plus a rule-level phase model,
// with directed scenarios followed by randomized ped/flash stimulus.
module tb_tlc_phase_fsm;

    localparam int         TPS = 4;
    localparam logic [3:0] T_G = 4'd8;
    localparam logic [3:0] T_Y = 4'd3;
    localparam logic [3:0] T_R = 4'd2;
    localparam logic [3:0] T_P = 4'd6;
    localparam logic [3:0] T_F = 4'd1;

    localparam int M_NSG  = 0;
    localparam int M_NSY  = 1;
    localparam int M_AR1  = 2;
    localparam int M_EWG  = 3;
    localparam int M_EWY  = 4;
    localparam int M_AR2  = 5;
    localparam int M_PED  = 6;
    localparam int M_FON  = 7;
    localparam int M_FOFF = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ped_req = 1'b0;
    logic       flash_mode = 1'b0;
    logic       force_done = 1'b0;
    logic [3:0] tcnt = 4'd0;
    int         tpre = 0;
    logic       timer_done;
    logic       timer_reload;
    logic [3:0] timer_load_value;
    logic       timer_enable;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       ped_walk;
    logic [2:0] phase;

    int   errors = 0;
    int   checks = 0;
    int   m_st = M_AR2;
    logic m_rel = 1'b1;
    logic m_ped = 1'b0;

    assign timer_done = (tcnt == 4'd0) | force_done;

    always #5 clk = ~clk;

    tlc_phase_fsm #(
        .GREEN_TIME (T_G),
        .YELLOW_TIME(T_Y),
        .RED_TIME   (T_R),
        .PED_TIME   (T_P),
        .FLASH_TIME (T_F)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ped_req         (ped_req),
        .flash_mode      (flash_mode),
        .timer_count     (tcnt),
        .timer_done      (timer_done),
        .timer_reload    (timer_reload),
        .timer_load_value(timer_load_value),
        .timer_enable    (timer_enable),
        .ns_light        (ns_light),
        .ew_light        (ew_light),
        .ped_walk        (ped_walk),
        .phase           (phase)
    );

    function automatic logic [3:0] m_dur(input int s);
        case (s)
            M_NSG, M_EWG:  return T_G;
            M_NSY, M_EWY:  return T_Y;
            M_PED:         return T_P;
            M_FON, M_FOFF: return T_F;
            default:       return T_R;
        endcase
    endfunction

    function automatic logic [2:0] m_ns(input int s);
        case (s)
            M_NSG:   return 3'b001;
            M_NSY:   return 3'b010;
            M_FON:   return 3'b010;
            M_FOFF:  return 3'b000;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] m_ew(input int s);
        case (s)
            M_EWG:   return 3'b001;
            M_EWY:   return 3'b010;
            M_FON:   return 3'b010;
            M_FOFF:  return 3'b000;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] m_phase(input int s);
        case (s)
            M_NSG:   return 3'd0;
            M_NSY:   return 3'd1;
            M_AR1:   return 3'd2;
            M_EWG:   return 3'd3;
            M_EWY:   return 3'd4;
            M_AR2:   return 3'd5;
            M_PED:   return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st  = M_AR2;
        m_rel = 1'b1;
        m_ped = 1'b0;
    endtask

    task automatic model_update(input logic rst, input logic done, input logic ped, input logic fl);
        int nxt;
        if (!rst) begin
            model_reset();
            return;
        end
        if (done && !m_rel) begin
            if (m_st == M_FON || m_st == M_FOFF)
                nxt = fl ? ((m_st == M_FON) ? M_FOFF : M_FON) : M_AR2;
            else if (fl)
                nxt = M_FON;
            else if (m_st == M_AR2)
                nxt = m_ped ? M_PED : M_NSG;
            else if (m_st == M_PED)
                nxt = M_NSG;
            else if (m_st == M_NSG) nxt = M_NSY;
            else if (m_st == M_NSY) nxt = M_AR1;
            else if (m_st == M_AR1) nxt = M_EWG;
            else if (m_st == M_EWG) nxt = M_EWY;
            else                    nxt = M_AR2;
            m_ped = (nxt == M_PED) ? 1'b0 : (m_ped | ped);
            m_rel = 1'b1;
            m_st  = nxt;
        end else begin
            m_rel = 1'b0;
            m_ped = m_ped | ped;
        end
    endtask

    task automatic compare_all();
        check_eq("phase",  phase,            m_phase(m_st));
        check_eq("ns",     ns_light,         m_ns(m_st));
        check_eq("ew",     ew_light,         m_ew(m_st));
        check_eq("walk",   ped_walk,         (m_st == M_PED));
        check_eq("reload", timer_reload,     m_rel);
        check_eq("load",   timer_load_value, m_dur(m_st));
        check_eq("enable", timer_enable,     1'b1);
    endtask

    // One clock: compare at the falling edge, then advance timer and model
    // with the values the DUT saw at the rising edge.
    task automatic step();
        logic       s_rel, s_en, s_done, s_ped, s_fl, s_rst;
        logic [3:0] s_val;
        @(negedge clk);
        compare_all();
        s_rel = timer_reload;
        s_val = timer_load_value;
        s_en  = timer_enable;
        @(posedge clk);
        s_done = timer_done;
        s_ped  = ped_req;
        s_fl   = flash_mode;
        s_rst  = reset_n;
        #1;
        model_update(s_rst, s_done, s_ped, s_fl);
        if (!s_rst) begin
            tcnt = 4'd0;
            tpre = 0;
        end else if (s_rel) begin
            tcnt = s_val;
            tpre = 0;
        end else if (s_en) begin
            if (tpre == TPS - 1) begin
                tpre = 0;
                if (tcnt != 4'd0) tcnt = tcnt - 4'd1;
            end else begin
                tpre++;
            end
        end
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (m_st != target && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, phase, m_phase(target));
    endtask

    task automatic measure_phase(input string tag, input int exp_len, input logic [2:0] exp_next);
        logic [2:0] cur;
        int         n;
        cur = phase;
        n   = 0;
        while (phase == cur && n < 200) begin
            step();
            n++;
        end
        check_eq({tag, "_len"},  n,     exp_len);
        check_eq({tag, "_next"}, phase, exp_next);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st0;
        model_reset();
        repeat (3) step();
        reset_n = 1'b1;

        // Reset clearance then one full free-running cycle.
        measure_phase("rst_ar2", T_R * TPS + 2, 3'd0);
        measure_phase("nsg", T_G * TPS + 2, 3'd1);
        measure_phase("nsy", T_Y * TPS + 2, 3'd2);
        measure_phase("ar1", T_R * TPS + 2, 3'd3);
        measure_phase("ewg", T_G * TPS + 2, 3'd4);
        measure_phase("ewy", T_Y * TPS + 2, 3'd5);
        measure_phase("ar2", T_R * TPS + 2, 3'd0);

        // Single-cycle pedestrian pulse during EW green.
        run_until("to_ewg", M_EWG, 200);
        repeat (5) step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        run_until("to_ped", M_PED, 200);
        check_eq("ped_walk_on", ped_walk, 1'b1);
        check_eq("ped_ns", ns_light, 3'b100);
        check_eq("ped_ew", ew_light, 3'b100);
        check_eq("ped_load", timer_load_value, T_P);
        run_until("ped_to_nsg", M_NSG, 60);
        run_until("to_ar2_b", M_AR2, 200);
        begin
            int n;
            n = 0;
            while (m_st == M_AR2 && n < 40) begin
                step();
                n++;
            end
        end
        check_eq("skip_ped", phase, 3'd0);

        // Flash requested mid NS green.
        repeat (10) step();
        flash_mode = 1'b1;
        run_until("to_fon", M_FON, 60);
        check_eq("fon_ns", ns_light, 3'b010);
        check_eq("fon_ew", ew_light, 3'b010);
        run_until("to_foff", M_FOFF, 20);
        check_eq("foff_ns", ns_light, 3'b000);
        check_eq("foff_ew", ew_light, 3'b000);
        repeat (20) step();
        flash_mode = 1'b0;
        run_until("flash_exit", M_AR2, 20);
        run_until("flash_nsg", M_NSG, 20);

        // Stale done forced high during a reload cycle must not advance.
        run_until("to_ewg_f", M_EWG, 200);
        st0 = m_st;
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        check_eq("force_hold", phase, m_phase(st0));

        // Asynchronous reset in the middle of EW yellow.
        run_until("to_ewy", M_EWY, 200);
        repeat (5) step();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_ns", ns_light, 3'b100);
        check_eq("arst_ew", ew_light, 3'b100);
        check_eq("arst_walk", ped_walk, 1'b0);
        check_eq("arst_reload", timer_reload, 1'b1);
        check_eq("arst_load", timer_load_value, T_R);
        model_reset();
        tcnt = 4'd0;
        tpre = 0;
        repeat (2) step();
        reset_n = 1'b1;
        measure_phase("rst2_ar2", T_R * TPS + 2, 3'd0);
        measure_phase("rst2_nsg", T_G * TPS + 2, 3'd1);

        // Randomized pedestrian pulses and flash toggles.
        repeat (2500) begin
            ped_req = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 149) == 0) flash_mode = ~flash_mode;
            step();
        end
        ped_req    = 1'b0;
        flash_mode = 1'b0;
        repeat (100) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
